sipo_word_deframer: RTL
=======================

// Module: sipo_word_deframer
// PURPOSE
//  Serial-in/parallel-out word collector with bit counter, selectable bit order and a
//  valid/ready output holding register. Sits behind the bit-sampling stage of the serial
//  receive path: accepts one qualified bit per i_en strobe and presents each complete
//  WIDTH-bit word to the downstream consumer, flagging overrun when words are not drained.
// PARAMETERS
//  WIDTH      8  word length in bits; legal range 2..32
//  LSB_FIRST  0  0: first received bit lands in o_data[WIDTH-1]; 1: first bit lands in o_data[0]
// PORTS
//  clk        in   1      rising-edge clock, single clock domain
//  i_sclr     in   1      synchronous reset, active-high
//  i_en       in   1      bit strobe: i_bit is sampled on this edge
//  i_bit      in   1      serial data bit
//  i_abort    in   1      discard the partially assembled word (framing error upstream)
//  i_ready    in   1      consumer accepts o_data when o_valid & i_ready
//  i_ovr_clr  in   1      clears the sticky o_overrun flag
//  o_data     out  WIDTH  assembled word; stable while o_valid=1
//  o_valid    out  1      o_data holds an unconsumed word
//  o_overrun  out  1      sticky: a completed word was dropped
//  o_busy     out  1      partial word in progress (bit count != 0)
//  o_count    out  CW     bits received in the current word, CW = clog2(WIDTH)
// BEHAVIOUR
//  Reset (i_sclr=1 on an edge): shift reg, count, o_data <= 0; o_valid, o_overrun, o_busy <= 0.
//   i_sclr overrides all other inputs that cycle, including mid-word and pending o_valid.
//  Shift on i_en & !i_abort: LSB_FIRST=0 -> s <= {s[WIDTH-2:0], i_bit};
//   LSB_FIRST=1 -> s <= {i_bit, s[WIDTH-1:1]}. No shift and no count change when i_en=0.
//  Counter: 0..WIDTH-1, +1 per accepted bit; wraps to 0 on the bit taken at count WIDTH-1
//   (word complete). Completion event = i_en & !i_abort & count==WIDTH-1.
//  Latency: on the completion edge the full word (including that final bit) is written
//   to o_data and o_valid rises; visible in the cycle after the last bit's i_en.
//  Handshake: transfer occurs on any edge with o_valid & i_ready; o_valid falls after it
//   unless a new word completes on the same edge. o_data must not change while
//   o_valid & !i_ready, except by reset.
//  Completion while o_valid & i_ready: new word loaded, o_valid stays 1 (back-to-back).
//  Completion while o_valid & !i_ready: new word dropped, o_data/o_valid unchanged,
//   o_overrun <= 1. Counter still wraps to 0; next word assembles normally.
//  o_overrun: set wins over i_ovr_clr on the same edge; otherwise i_ovr_clr clears it.
//  i_abort: count <= 0, shift reg <= 0 next edge; abort wins over a simultaneous i_en
//   (bit discarded, no completion). Does not affect o_data/o_valid/o_overrun.
//  o_busy = (count != 0), registered consistent with o_count.
//  WIDTH not a power of two: counter compare at WIDTH-1, values >= WIDTH unreachable.
// STRUCTURE
//  Shared package serial_pkg: clog2 constant function, bit-order constants
//   (ORDER_MSB_FIRST=0, ORDER_LSB_FIRST=1), default word width constant shared with the TX side.
//  One sub-module: mod_counter #(MOD) - enable, sync clear, terminal-count output;
//   instantiated with MOD=WIDTH, i_sclr|i_abort as clear. Shift reg, holding reg,
//   handshake and overrun logic stay in this module.
// TESTING
//  1 WIDTH=8, LSB_FIRST=0, i_ready=1, bits 1,1,0,0,0,0,0,1 on consecutive i_en ->
//    o_valid one cycle after 8th bit, o_data=8'hC1, o_valid low the following cycle.
//  2 LSB_FIRST=1, same bits -> o_data=8'h83; o_count steps 0..7 then 0.
//  3 i_ready=0, send 8'hC1 then 8'h5A -> o_data stays 8'hC1, o_overrun=1; raise i_ready ->
//    one transfer of 8'hC1, o_valid=0; pulse i_ovr_clr -> o_overrun=0.
//  4 Word 2 completes on the same edge as i_ready takes word 1 -> o_valid stays 1,
//    o_data changes 8'hC1 -> 8'h5A, o_overrun stays 0.
//  5 After 5 bits assert i_abort with i_en=1 -> o_count=0, o_busy=0; next 8 bits 8'hA0
//    yield o_data=8'hA0 exactly.
//  6 Assert i_sclr at count=3 with o_valid=1 and o_overrun=1 -> all outputs 0 next cycle;
//    gapped i_en (1 strobe per 4 clk) still assembles 8'hC1 correctly.

Source files
------------

// File: rtl/serial_pkg.sv
// Constants and helpers shared by the serial transmit and receive paths.
package serial_pkg;

  localparam int ORDER_MSB_FIRST = 0;
  localparam int ORDER_LSB_FIRST = 1;
  localparam int DEFAULT_WORD_W  = 8;

  // Number of bits needed to index n values; gives 1 for n <= 2.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/mod_counter.sv
// Modulo-MOD up counter with enable, synchronous clear and a terminal-count flag.
module mod_counter
  import serial_pkg::*;
#(
  parameter  int MOD = DEFAULT_WORD_W,
  localparam int CW  = clog2(MOD)
) (
  input  logic          clk,
  input  logic          i_clr,
  input  logic          i_en,
  output logic [CW-1:0] o_count,
  output logic          o_tc
);

  localparam logic [CW-1:0] LAST = CW'(MOD - 1);

  assign o_tc = (o_count == LAST);

  // Wrap explicitly at MOD-1 so non-power-of-two moduli never reach MOD.
  always_ff @(posedge clk) begin
    if (i_clr)
      o_count <= '0;
    else if (i_en)
      o_count <= o_tc ? '0 : o_count + 1'b1;
  end

endmodule

// File: rtl/sipo_word_deframer.sv
// Collects serial bits into WIDTH-bit words and offers them on a valid/ready holding register.
module sipo_word_deframer
  import serial_pkg::*;
#(
  parameter  int WIDTH     = DEFAULT_WORD_W,
  parameter  int LSB_FIRST = ORDER_MSB_FIRST,
  localparam int CW        = clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             i_sclr,
  input  logic             i_en,
  input  logic             i_bit,
  input  logic             i_abort,
  input  logic             i_ready,
  input  logic             i_ovr_clr,
  output logic [WIDTH-1:0] o_data,
  output logic             o_valid,
  output logic             o_overrun,
  output logic             o_busy,
  output logic [CW-1:0]    o_count
);

  logic [WIDTH-1:0] shift_p0;
  logic [WIDTH-1:0] shift_nxt;
  logic [WIDTH-1:0] data_p1;
  logic             vld_p1;
  logic             ovr_q;
  logic             accept;
  logic             tc;
  logic             complete;
  logic             load;

  assign accept   = i_en & ~i_abort;
  assign complete = accept & tc;
  // A finished word is kept only if the holding register is empty or being drained now.
  assign load     = complete & (~vld_p1 | i_ready);

  mod_counter #(.MOD(WIDTH)) u_bit_cnt (
    .clk     (clk),
    .i_clr   (i_sclr | i_abort),
    .i_en    (accept),
    .o_count (o_count),
    .o_tc    (tc)
  );

  always_comb begin
    shift_nxt = shift_p0;
    if (LSB_FIRST == ORDER_LSB_FIRST)
      shift_nxt = {i_bit, shift_p0[WIDTH-1:1]};
    else
      shift_nxt = {shift_p0[WIDTH-2:0], i_bit};
  end

  // Stage 0: bit assembly
  always_ff @(posedge clk) begin
    if (i_sclr || i_abort)
      shift_p0 <= '0;
    else if (accept)
      shift_p0 <= shift_nxt;
  end

  // Stage 1: holding register and handshake
  always_ff @(posedge clk) begin
    if (i_sclr) begin
      data_p1 <= '0;
      vld_p1  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      if (load)
        data_p1 <= shift_nxt;
      if (load)
        vld_p1 <= 1'b1;
      else if (i_ready)
        vld_p1 <= 1'b0;
      if (complete && vld_p1 && !i_ready)
        ovr_q <= 1'b1;
      else if (i_ovr_clr)
        ovr_q <= 1'b0;
    end
  end

  assign o_data    = data_p1;
  assign o_valid   = vld_p1;
  assign o_overrun = ovr_q;
  assign o_busy    = (o_count != '0);

endmodule
